// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } sw_state_e;

    localparam logic [3:0] DP_PATTERN = 4'b1011;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    function automatic logic is_counting(sw_state_e s);
        return (s == RUNNING) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and display-facing outputs of the stopwatch core.
interface stopwatch_if;
    logic        startStop;
    logic        lapClear;
    logic [15:0] value;
    logic [3:0]  point;
    logic        running;
    logic        overflow;

    modport master (output startStop, lapClear,
                    input  value, point, running, overflow);
    modport slave  (input  startStop, lapClear,
                    output value, point, running, overflow);
endinterface

// File: rtl/bcd_digit.sv
// One decade counter stage; stages are chained through carryIn/carryOut.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       carryIn,
    output logic [3:0] digit,
    output logic       carryOut
);

    logic [3:0] digit_q, digit_d;

    // Wrapping on >= keeps the digit inside 0-9 even from an illegal value.
    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (carryIn) begin
            digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) digit_q <= '0;
        else       digit_q <= digit_d;
    end

    assign digit    = digit_q;
    assign carryOut = carryIn & (digit_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_core.sv
// SS.hh stopwatch: button conditioning, tick prescaler, control FSM and
// a four-stage BCD ripple counter feeding the display driver.
//
//   state   | meaning
//   IDLE    | cleared, waiting for start
//   RUNNING | counting, display shows live count
//   PAUSED  | count and prescaler frozen
//   LAP     | counting, display frozen on the lap snapshot
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 1000000,
    parameter int DIV_WIDTH = 20
) (
    input  logic      clock,
    input  logic      reset,
    stopwatch_if.slave bus
);

    localparam logic [DIV_WIDTH-1:0] TICK_LAST = DIV_WIDTH'(TICK_DIV - 1);

    logic [1:0] meta_q, sync_q, prev_q;
    logic [1:0] pulse;
    logic       ss_pulse, lc_pulse;

    sw_state_e  state_q, state_d;
    logic       capture, clear_all;

    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 counting, tick;

    logic [4:0]  carry;
    logic [15:0] live;
    logic [15:0] snap_q, snap_d;
    logic        overflow_q, overflow_d;
    logic        running_q, running_d;

    // Bit 0 is startStop, bit 1 is lapClear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= {bus.lapClear, bus.startStop};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse    = sync_q & ~prev_q;
    assign ss_pulse = pulse[0];
    assign lc_pulse = pulse[1];

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        clear_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_pulse) state_d = RUNNING;
            end
            RUNNING: begin
                if (ss_pulse) begin
                    state_d = PAUSED;
                end else if (lc_pulse) begin
                    state_d = LAP;
                    capture = 1'b1;
                end
            end
            LAP: begin
                if (ss_pulse)      state_d = PAUSED;
                else if (lc_pulse) state_d = RUNNING;
            end
            PAUSED: begin
                if (ss_pulse) begin
                    state_d = RUNNING;
                end else if (lc_pulse) begin
                    state_d   = IDLE;
                    clear_all = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign counting = is_counting(state_q);
    assign tick     = counting && (presc_q == TICK_LAST);

    always_comb begin
        presc_d = presc_q;
        if (clear_all)     presc_d = '0;
        else if (tick)     presc_d = '0;
        else if (counting) presc_d = presc_q + DIV_WIDTH'(1);
    end

    assign carry[0] = tick;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clock    (clock),
            .reset    (reset),
            .clear    (clear_all),
            .carryIn  (carry[i]),
            .digit    (live[4*i +: 4]),
            .carryOut (carry[i+1])
        );
    end

    // Snapshot takes the pre-tick count when a tick lands on the capture cycle.
    always_comb begin
        snap_d = snap_q;
        if (clear_all)    snap_d = '0;
        else if (capture) snap_d = live;
    end

    assign overflow_d = clear_all ? 1'b0 : (overflow_q | carry[4]);
    assign running_d  = is_counting(state_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            snap_q     <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            snap_q     <= snap_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    assign bus.value    = (state_q == LAP) ? snap_q : live;
    assign bus.point    = DP_PATTERN;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a cycle-level reference model and
// an expected-output queue checked every cycle.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_if sw();

    stopwatch_core #(.TICK_DIV(TD), .DIV_WIDTH(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (sw)
    );

    typedef struct {
        string       tag;
        logic [21:0] exp;
    } sb_t;

    sb_t   sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    edge_n  = 0;
    int    fire_ss = -1;
    int    fire_lc = -1;
    string cur_tag = "init";

    sw_state_e m_state = IDLE;
    int        m_cnt   = 0;
    int        m_snap  = 0;
    int        m_presc = 0;
    bit        m_ovf   = 1'b0;

    function automatic logic [15:0] to_bcd(int k);
        return {4'(k / 1000 % 10), 4'(k / 100 % 10), 4'(k / 10 % 10), 4'(k % 10)};
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit ss, lc, tk, act;
        int pre;
        if (rst) begin
            m_state = IDLE; m_cnt = 0; m_snap = 0; m_presc = 0; m_ovf = 1'b0;
        end else begin
            ss  = (edge_n == fire_ss);
            lc  = (edge_n == fire_lc);
            pre = m_cnt;
            act = (m_state == RUNNING) || (m_state == LAP);
            tk  = act && (m_presc == TD - 1);
            if (act) m_presc = tk ? 0 : m_presc + 1;
            if (tk) begin
                m_cnt = (m_cnt + 1) % 10000;
                if (m_cnt == 0) m_ovf = 1'b1;
            end
            case (m_state)
                IDLE:    if (ss) m_state = RUNNING;
                RUNNING: if (ss) m_state = PAUSED;
                         else if (lc) begin m_state = LAP; m_snap = pre; end
                LAP:     if (ss) m_state = PAUSED;
                         else if (lc) m_state = RUNNING;
                default: if (ss) m_state = RUNNING;
                         else if (lc) begin
                             m_state = IDLE; m_cnt = 0; m_snap = 0; m_presc = 0; m_ovf = 1'b0;
                         end
            endcase
        end
    endtask

    task automatic sb_push();
        sb_t e;
        logic run;
        run   = (m_state == RUNNING) || (m_state == LAP);
        e.tag = cur_tag;
        e.exp = {(m_state == LAP) ? to_bcd(m_snap) : to_bcd(m_cnt), 4'b1011, run, m_ovf};
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        logic [21:0] obs;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e   = sb_q.pop_front();
            obs = {sw.value, sw.point, sw.running, sw.overflow};
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_update();
        sb_push();
        @(negedge clk);
        sb_check();
    endtask

    task automatic press(bit ss, bit lc);
        if (ss) begin sw.startStop = 1'b1; fire_ss = edge_n + 3; end
        if (lc) begin sw.lapClear  = 1'b1; fire_lc = edge_n + 3; end
        repeat (5) step();
        sw.startStop = 1'b0;
        sw.lapClear  = 1'b0;
    endtask

    task automatic run_until(int target, int budget);
        int g = 0;
        while (!(m_cnt == target && m_presc == 0) && g < budget) begin
            step();
            g++;
        end
        n_tests++;
        assert (g < budget) else begin
            n_fail++;
            $error("FAIL timeout_%0d waited=%0d limit=%0d", target, g, budget);
        end
    endtask

    initial begin
        sw.startStop = 1'b0;
        sw.lapClear  = 1'b0;

        cur_tag = "reset";
        repeat (3) step();
        chk("rst_value", sw.value, 16'h0000);
        chk("rst_point", 16'(sw.point), 16'h000b);
        chk("rst_running", 16'(sw.running), 16'h0000);
        chk("rst_overflow", 16'(sw.overflow), 16'h0000);
        rst = 1'b0;

        cur_tag = "idle_quiet";
        repeat (100) step();

        cur_tag = "count";
        press(1'b1, 1'b0);
        repeat (158) step();
        chk("count_40", sw.value, 16'h0040);

        cur_tag = "lap";
        run_until(123, 2000);
        press(1'b0, 1'b1);
        chk("lap_snap", sw.value, 16'h0123);
        chk("lap_running", 16'(sw.running), 16'h0001);
        repeat (80) step();
        chk("lap_frozen", sw.value, 16'h0123);
        press(1'b0, 1'b1);
        chk("lap_return_value", sw.value, 16'h0145);
        chk("lap_return_running", 16'(sw.running), 16'h0001);

        cur_tag = "wrap";
        run_until(9998, 45000);
        chk("wrap_9998", sw.value, 16'h9998);
        chk("wrap_pre_ovf", 16'(sw.overflow), 16'h0000);
        run_until(1, 20);
        chk("wrap_0001", sw.value, 16'h0001);
        chk("wrap_ovf_sticky", 16'(sw.overflow), 16'h0001);

        cur_tag = "pause";
        press(1'b1, 1'b0);
        repeat (50) step();
        chk("pause_hold", sw.value, 16'h0001);
        chk("pause_running", 16'(sw.running), 16'h0000);
        press(1'b0, 1'b1);
        chk("clear_value", sw.value, 16'h0000);
        chk("clear_ovf", 16'(sw.overflow), 16'h0000);
        chk("clear_running", 16'(sw.running), 16'h0000);

        cur_tag = "both";
        press(1'b1, 1'b1);
        chk("both_running", 16'(sw.running), 16'h0001);
        run_until(567, 3000);
        chk("pre_reset_value", sw.value, 16'h0567);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_value", sw.value, 16'h0000);
        chk("async_rst_running", 16'(sw.running), 16'h0000);
        cur_tag = "in_reset";
        repeat (2) step();
        rst = 1'b0;

        cur_tag = "restart";
        press(1'b1, 1'b0);
        repeat (2) step();
        chk("restart_value", sw.value, 16'h0001);
        chk("restart_running", 16'(sw.running), 16'h0001);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
